// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register write scoreboard with ID-stage interlock and stall watchdog (option: SCOREBOARD_R0_EXEMPT_EN)
module reg_scoreboard #(
    parameter int NREGS        = 16,
    parameter int MAX_INFLIGHT = 3,
    parameter int STALL_LIMIT  = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             IF_ID_valid,
    input  logic [3:0]       IF_ID_op1,
    input  logic [3:0]       IF_ID_op2,
    input  logic [3:0]       IF_ID_dest,
    input  logic             IF_ID_RegWrite,
    input  logic             wb_valid,
    input  logic [3:0]       wb_dest,
    output logic             hasHazard,
    output logic             PCWrite,
    output logic             IF_ID_Hold,
    output logic             ID_EX_CtrlFlush,
    output logic [NREGS-1:0] pending_mask,
    output logic             sb_error,
    output logic             deadlock
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);
`ifdef SCOREBOARD_R0_EXEMPT_EN
    localparam logic R0_EXEMPT = 1'b1;
`else
    localparam logic R0_EXEMPT = 1'b0;
`endif

    logic [CW-1:0]    cnt_q [NREGS];
    logic [CW-1:0]    cnt_d [NREGS];
    logic [SW-1:0]    stall_run_q, stall_run_d;
    logic             sb_error_q, sb_error_d;
    logic             deadlock_q, deadlock_d;

    logic [NREGS-1:0] pending;
    logic             hazard;
    logic             full;
    logic             stall;
    logic             issue;
    logic             wb_eff;
    logic             inc;
    logic             hit;

    // Pending view of the counters; register 0 is never pending when exempt
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            pending[r] = (cnt_q[r] != '0) && !(R0_EXEMPT && (r == 0));
        end
    end

    // Interlock decision, counter bookkeeping, error and watchdog next-state
    always_comb begin
        hazard = IF_ID_valid & (pending[IF_ID_op1] | pending[IF_ID_op2]);
        full   = IF_ID_valid & IF_ID_RegWrite & (cnt_q[IF_ID_dest] == CW'(MAX_INFLIGHT));
        stall  = hazard | full;
        issue  = IF_ID_valid & IF_ID_RegWrite & ~stall;
        wb_eff = wb_valid & ~(R0_EXEMPT & (wb_dest == 4'd0));
        inc    = 1'b0;
        hit    = 1'b0;

        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            inc = issue & (IF_ID_dest == 4'(r)) & ~(R0_EXEMPT && (r == 0));
            hit = wb_eff & (wb_dest == 4'(r));
            if (inc && !hit) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (hit && !inc && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end

        // A retire that meets a same-cycle issue to the same register is legal
        sb_error_d = sb_error_q |
                     (wb_eff & (cnt_q[wb_dest] == '0) & ~(issue & (IF_ID_dest == wb_dest)));

        if (!stall) begin
            stall_run_d = '0;
        end else if (stall_run_q == SW'(STALL_LIMIT)) begin
            stall_run_d = stall_run_q;
        end else begin
            stall_run_d = stall_run_q + 1'b1;
        end
        deadlock_d = deadlock_q | (stall_run_d == SW'(STALL_LIMIT));
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_run_q <= '0;
            sb_error_q  <= 1'b0;
            deadlock_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_run_q <= stall_run_d;
            sb_error_q  <= sb_error_d;
            deadlock_q  <= deadlock_d;
        end
    end

    // Interlock outputs are forced to free-running while reset is held
    always_comb begin
        hasHazard       = reset & hazard;
        PCWrite         = ~(reset & stall);
        IF_ID_Hold      = reset & stall;
        ID_EX_CtrlFlush = reset & stall;
        pending_mask    = pending;
        sb_error        = sb_error_q;
        deadlock        = deadlock_q;
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard bench for reg_scoreboard with randomized stimulus
module tb_reg_scoreboard;
    logic        clock = 1'b0;
    logic        reset;
    logic        IF_ID_valid;
    logic [3:0]  IF_ID_op1, IF_ID_op2, IF_ID_dest;
    logic        IF_ID_RegWrite;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic        hasHazard, PCWrite, IF_ID_Hold, ID_EX_CtrlFlush;
    logic [15:0] pending_mask;
    logic        sb_error, deadlock;

    reg_scoreboard dut (
        .clock(clock), .reset(reset),
        .IF_ID_valid(IF_ID_valid), .IF_ID_op1(IF_ID_op1), .IF_ID_op2(IF_ID_op2),
        .IF_ID_dest(IF_ID_dest), .IF_ID_RegWrite(IF_ID_RegWrite),
        .wb_valid(wb_valid), .wb_dest(wb_dest),
        .hasHazard(hasHazard), .PCWrite(PCWrite), .IF_ID_Hold(IF_ID_Hold),
        .ID_EX_CtrlFlush(ID_EX_CtrlFlush), .pending_mask(pending_mask),
        .sb_error(sb_error), .deadlock(deadlock)
    );

    always #5 clock = ~clock;

`ifdef SCOREBOARD_R0_EXEMPT_EN
    localparam bit R0X = 1'b1;
`else
    localparam bit R0X = 1'b0;
`endif

    typedef struct {
        logic        hz, pcw, hold, flush;
        logic [15:0] pm;
        logic        err, dl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference state: outstanding writes per register, flags, stall streak
    int   m_cnt[16];
    bit   m_err, m_dl;
    int   m_run;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: every cycle the DUT presents a response, compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hasHazard",       {15'd0, hasHazard},       {15'd0, e.hz});
                chk("PCWrite",         {15'd0, PCWrite},         {15'd0, e.pcw});
                chk("IF_ID_Hold",      {15'd0, IF_ID_Hold},      {15'd0, e.hold});
                chk("ID_EX_CtrlFlush", {15'd0, ID_EX_CtrlFlush}, {15'd0, e.flush});
                chk("pending_mask",    pending_mask,             e.pm);
                chk("sb_error",        {15'd0, sb_error},        {15'd0, e.err});
                chk("deadlock",        {15'd0, deadlock},        {15'd0, e.dl});
            end
        end
    end

    function automatic bit pend(input int r);
        return (m_cnt[r] > 0) && !(R0X && r == 0);
    endfunction

    // drive one cycle, record the expected response, then advance the model past the edge
    task automatic cyc(input bit rst, input bit v, input int op1, input int op2,
                       input int dest, input bit rw, input bit wbv, input int wbd);
        exp_t e;
        bit hz, full, stall, issue, wb_eff, err_now;
        @(posedge clock);
        #1;
        reset = rst; IF_ID_valid = v; IF_ID_op1 = 4'(op1); IF_ID_op2 = 4'(op2);
        IF_ID_dest = 4'(dest); IF_ID_RegWrite = rw; wb_valid = wbv; wb_dest = 4'(wbd);

        hz    = v && (pend(op1) || pend(op2));
        full  = v && rw && (m_cnt[dest] == 3);
        stall = hz || full;
        e.hz    = rst && hz;
        e.pcw   = !(rst && stall);
        e.hold  = rst && stall;
        e.flush = rst && stall;
        for (int r = 0; r < 16; r++) e.pm[r] = pend(r);
        e.err = m_err;
        e.dl  = m_dl;
        exp_q.push_back(e);

        if (!rst) begin
            for (int r = 0; r < 16; r++) m_cnt[r] = 0;
            m_err = 0; m_dl = 0; m_run = 0;
        end else begin
            issue   = v && rw && !stall;
            wb_eff  = wbv && !(R0X && wbd == 0);
            err_now = wb_eff && m_cnt[wbd] == 0 && !(issue && dest == wbd);
            if (err_now) m_err = 1;
            if (issue && !(R0X && dest == 0)) m_cnt[dest] = m_cnt[dest] + 1;
            if (wb_eff && m_cnt[wbd] > 0) m_cnt[wbd] = m_cnt[wbd] - 1;
            m_run = stall ? ((m_run < 15) ? m_run + 1 : 15) : 0;
            if (m_run == 15) m_dl = 1;
        end
    endtask

    initial begin
        int op1, op2, dest, wbd, k;
        bit v, rw, wbv, rst;
        reset = 0; IF_ID_valid = 0; IF_ID_op1 = 0; IF_ID_op2 = 0; IF_ID_dest = 0;
        IF_ID_RegWrite = 0; wb_valid = 0; wb_dest = 0;
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        m_err = 0; m_dl = 0; m_run = 0;
        @(posedge clock);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // single producer, dependent consumer, release after writeback
        cyc(1, 1, 1, 2, 5, 1, 0, 0);
        cyc(1, 1, 5, 1, 6, 1, 0, 0);
        cyc(1, 1, 5, 1, 6, 1, 1, 5);
        cyc(1, 1, 5, 1, 6, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 6);
        // fill register 3 to the in-flight limit, then retire one
        for (int i = 0; i < 4; i++) cyc(1, 1, 8, 8, 3, 1, 0, 0);
        cyc(1, 1, 8, 8, 3, 1, 1, 3);
        cyc(1, 1, 8, 8, 3, 1, 0, 0);
        cyc(1, 1, 8, 8, 3, 1, 0, 0);
        // issue and retire to the same register in one cycle
        cyc(1, 1, 8, 8, 7, 1, 0, 0);
        cyc(1, 1, 8, 8, 7, 1, 1, 7);
        // issue with retire while the count is zero is not an error
        cyc(1, 1, 8, 8, 10, 1, 1, 10);
        // self-dependency sees only pre-issue state
        cyc(1, 1, 11, 11, 11, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // underflow writebacks
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 9);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // watchdog, then reset in the middle of the stall
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 8, 8, 4, 1, 0, 0);
        for (int i = 0; i < 17; i++) cyc(1, 1, 4, 8, 12, 1, 0, 0);
        cyc(0, 1, 4, 8, 12, 1, 0, 0);
        cyc(1, 1, 4, 8, 12, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic with writebacks biased toward pending registers
        for (int i = 0; i < 2000; i++) begin
            rst  = ($urandom_range(0, 99) != 0);
            v    = ($urandom_range(0, 3) != 0);
            rw   = ($urandom_range(0, 4) != 0);
            dest = $urandom_range(0, 15);
            op1  = $urandom_range(0, 15);
            op2  = $urandom_range(0, 15);
            if ($urandom_range(0, 2) == 0) dest = $urandom_range(0, 3);
            wbv = 0; wbd = $urandom_range(0, 15);
            k = $urandom_range(0, 19);
            if (k < 10) begin
                for (int t = 0; t < 16; t++) begin
                    if (m_cnt[(wbd + t) % 16] > 0 && !wbv) begin
                        wbd = (wbd + t) % 16;
                        wbv = 1;
                    end
                end
            end else if (k == 10) begin
                wbv = 1;
            end
            cyc(rst, v, op1, op2, dest, rw, wbv, wbd);
        end

        @(negedge clock);
        @(negedge clock);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight register writes for the pipelined processor and drives the interlock signals into the IF/ID and ID/EX stages.
- It is the writer-side counterpart of the combinational hazard check. Each instruction leaving ID marks its destination register pending. Each writeback retires that mark.
- An instruction in ID whose sources are pending is stalled until the producer writes back.

Parameters:
- NREGS, 16, number of architectural registers (register IDs are 4 bits).
- MAX_INFLIGHT, 3, maximum outstanding writes per register. Per-register counter width CW = clog2(MAX_INFLIGHT+1).
- STALL_LIMIT, 15, number of consecutive stall cycles after which the deadlock flag sets.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- IF_ID_valid  in  1  the ID-stage instruction is valid.
- IF_ID_op1  in  4  source register 1 of the ID instruction.
- IF_ID_op2  in  4  source register 2 of the ID instruction.
- IF_ID_dest  in  4  destination register of the ID instruction.
- IF_ID_RegWrite  in  1  the ID instruction writes IF_ID_dest.
- wb_valid  in  1  a writeback is retiring this cycle.
- wb_dest  in  4  register being written back.
- hasHazard  out  1  a source of the ID instruction is pending.
- PCWrite  out  1  PC update enable (0 = hold).
- IF_ID_Hold  out  1  hold the IF/ID register.
- ID_EX_CtrlFlush  out  1  zero the ID/EX control bits (insert a bubble).
- pending_mask  out  NREGS  bit r = (cnt[r] != 0).
- sb_error  out  1  sticky: a writeback arrived for a register with cnt 0.
- deadlock  out  1  sticky: consecutive stall count reached STALL_LIMIT.

Behaviour:
- State:
  - cnt[0..NREGS-1], CW bits each.
  - stall_run, clog2(STALL_LIMIT+1) bits.
  - sb_error and deadlock flags.
- Reset (reset==0 at a clock edge):
  - All cnt, stall_run, sb_error and deadlock clear to 0.
  - While reset is low, outputs are forced to PCWrite=1, IF_ID_Hold=0, ID_EX_CtrlFlush=0, hasHazard=0.
  - pending_mask reads 0 from the cycle after the reset edge.
  - Reset asserted mid-stall discards all pending state. No writeback is needed afterwards.
- Combinational, from registered state (zero latency):
  - hasHazard = IF_ID_valid & (pending[op1] | pending[op2]).
  - full = IF_ID_valid & IF_ID_RegWrite & (cnt[IF_ID_dest] == MAX_INFLIGHT).
  - stall = hasHazard | full.
  - PCWrite = ~stall; IF_ID_Hold = stall; ID_EX_CtrlFlush = stall.
- A writeback in the current cycle does NOT bypass the check. The stall releases one cycle after the wb edge, when cnt reads 0.
- issue = IF_ID_valid & IF_ID_RegWrite & ~stall.
- Counter update per register r at each clock edge:
  - inc = issue & (IF_ID_dest == r).
  - dec = wb_valid & (wb_dest == r) & (cnt[r] != 0).
  - inc & dec: cnt unchanged.
  - inc only: +1. Never exceeds MAX_INFLIGHT, because full blocks the issue.
  - dec only: -1.
- Writeback to a register with cnt 0 (and no simultaneous inc to it):
  - cnt stays 0; no wrap to all-ones.
  - sb_error sets and holds until reset.
- Writeback to register r together with issue to r while cnt[r]==0: counts as a normal retire. Result is cnt=0 after the edge and no error.
- Self-dependency (op == dest of the same instruction) depends only on the pending state before issue. The instruction marks its own dest after issuing.
- Watchdog:
  - stall_run increments each cycle stall==1 and saturates at STALL_LIMIT.
  - It clears on any cycle with stall==0.
  - deadlock sets when stall_run reaches STALL_LIMIT and holds until reset.
  - It does not alter the stall outputs.

Optional Feature:
- Macro SCOREBOARD_R0_EXEMPT_EN.
- Defined:
  - Register 0 is hardwired zero. cnt[0] never increments, pending_mask[0]=0, op1/op2==0 never hazard.
  - wb_dest==0 is ignored and does not set sb_error.
- Undefined: register 0 is tracked exactly like every other register.

Test Plan:
- Reset, then IF_ID_valid=1, RegWrite=1, dest=5, ops 1/2 -> no stall. Next cycle pending_mask=0x0020 and cnt[5]=1.
- cnt[5]=1, ID instruction op1=5 -> hasHazard=1, PCWrite=0, IF_ID_Hold=1, ID_EX_CtrlFlush=1. wb_valid, wb_dest=5 -> stall drops the following cycle.
- Issue to dest 3 three times with no writeback (MAX_INFLIGHT=3), then a fourth with no source hazard -> full stall with hasHazard=0 and cnt[3] held at 3. One wb to 3 -> fourth issues and cnt[3] returns to 3.
- Same-cycle issue dest=7 and wb dest=7 with cnt[7]=1 -> cnt[7] stays 1 and sb_error=0.
- wb_valid, wb_dest=9 with cnt[9]=0 -> cnt[9]=0 and sb_error=1 until reset. With SCOREBOARD_R0_EXEMPT_EN, wb_dest=0 -> sb_error stays 0.
- Hold a source hazard with no writeback for 15 cycles -> deadlock=1 on cycle 15. Pull reset low mid-stall -> pending_mask=0, deadlock=0, PCWrite=1.
